// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO for the conv3x3 datapath.
// Depth is 2**ADDR_WIDTH words. Read data is registered, so a word is valid
// the cycle after its read is accepted. Status flags are registered from the
// next-state occupancy count.
// Optional macro SYNC_FIFO_OUT_REG_EN adds a second output register stage,
// which raises the read latency to 2 cycles.
module sync_fifo #(
   parameter int unsigned ADDR_WIDTH       = 4,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned ALMOST_FULL_NUM  = 11,
   parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  almost_full,
   output logic                  empty,
   output logic                  almost_empty
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   AF_LVL    = (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [ADDR_WIDTH:0]   AE_LVL    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q,  count_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  full_q, full_d;
   logic                  almost_full_q, almost_full_d;
   logic                  empty_q, empty_d;
   logic                  almost_empty_q, almost_empty_d;
   logic                  wr_acc, rd_acc;

   // Accept decisions, pointer/count next state and flags from next-state count.
   always_comb begin
      wr_acc    = wr_en && !full_q;
      rd_acc    = rd_en && !empty_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      rd_data_d = rd_data_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
         rd_data_d = mem_q[rd_ptr_q];
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      full_d         = (count_d == DEPTH_CNT);
      almost_full_d  = (count_d >= AF_LVL);
      empty_d        = (count_d == '0);
      almost_empty_d = (count_d <= AE_LVL);
   end

   // Control state and registered read data; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rd_data_q      <= '0;
         full_q         <= 1'b0;
         almost_full_q  <= 1'b0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         rd_data_q      <= rd_data_d;
         full_q         <= full_d;
         almost_full_q  <= almost_full_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
      end
   end

   // Storage array; contents survive reset, but no write lands while in reset.
   always_ff @(posedge clk) begin
      if (rst && wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

`ifdef SYNC_FIFO_OUT_REG_EN
   logic [DATA_WIDTH-1:0] rd_out_q;

   // Second output stage: loads every cycle, clears on reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_out_q <= '0;
      end else begin
         rd_out_q <= rd_data_q;
      end
   end

   assign rd_data = rd_out_q;
`else
   assign rd_data = rd_data_q;
`endif

   assign full         = full_q;
   assign almost_full  = almost_full_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo.
// A directed vector table walks the reset/fill/overflow/drain/underflow/reset
// scenarios with hand-derived expectations; every cycle is also compared
// against a queue-based reference model, which then drives a randomized run.
module tb_sync_fifo;

   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int AFN   = 11;
   localparam int AEN   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] wr_data;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          full;
   logic          almost_full;
   logic          empty;
   logic          almost_empty;

   int n_tests = 0;
   int n_fail  = 0;

   sync_fifo #(
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .ALMOST_FULL_NUM (AFN),
      .ALMOST_EMPTY_NUM(AEN)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .full        (full),
      .almost_full (almost_full),
      .empty       (empty),
      .almost_empty(almost_empty)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_rd  = '0;
   logic [DW-1:0] m_out = '0;

   task automatic model_step(input bit r, input bit we, input bit re, input logic [DW-1:0] wd);
      bit wacc;
      bit racc;
      m_out = r ? m_rd : '0;
      if (!r) begin
         mq.delete();
         m_rd = '0;
      end else begin
         wacc = we && (mq.size() < DEPTH);
         racc = re && (mq.size() > 0);
         if (racc) m_rd = mq.pop_front();
         if (wacc) mq.push_back(wd);
      end
   endtask

   function automatic logic [DW-1:0] model_rd();
`ifdef SYNC_FIFO_OUT_REG_EN
      return m_out;
`else
      return m_rd;
`endif
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle, advance the model, then compare all outputs against it.
   task automatic cyc(input bit r, input bit we, input bit re, input logic [DW-1:0] wd);
      rst     = r;
      wr_en   = we;
      rd_en   = re;
      wr_data = wd;
      @(posedge clk);
      model_step(r, we, re, wd);
      #1;
      chk("model_rd_data",      rd_data,      model_rd());
      chk("model_full",         full,         DW'(mq.size() == DEPTH));
      chk("model_almost_full",  almost_full,  DW'(mq.size() >= AFN));
      chk("model_empty",        empty,        DW'(mq.size() == 0));
      chk("model_almost_empty", almost_empty, DW'(mq.size() <= AEN));
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            r;
      bit            we;
      bit            re;
      logic [DW-1:0] wd;
      logic [DW-1:0] e_rd;
      bit            e_full;
      bit            e_af;
      bit            e_empty;
      bit            e_ae;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input bit r, input bit we, input bit re, input logic [DW-1:0] wd,
                      input logic [DW-1:0] e_rd, input int cnt);
      vec_t v;
      v.r       = r;
      v.we      = we;
      v.re      = re;
      v.wd      = wd;
      v.e_rd    = e_rd;
      v.e_full  = (cnt == DEPTH);
      v.e_af    = (cnt >= AFN);
      v.e_empty = (cnt == 0);
      v.e_ae    = (cnt <= AEN);
      tbl.push_back(v);
   endtask

   initial begin
      rst     = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      wr_data = '0;

      // Reset held for 20 cycles.
      for (int i = 0; i < 20; i++) add(0, 0, 0, '0, '0, 0);
      // Fill with 0..15.
      for (int i = 0; i < 16; i++) add(1, 1, 0, DW'(i), '0, i + 1);
      // Overflow attempt is ignored.
      add(1, 1, 0, 16'hAAAA, '0, 16);
      // Drain: 0..15 in order.
      for (int i = 0; i < 16; i++) add(1, 0, 1, '0, DW'(i), 15 - i);
      // Underflow: rd_data holds 15.
      add(1, 0, 1, '0, 16'd15, 0);
      add(1, 0, 1, '0, 16'd15, 0);
      // Three words, then simultaneous read+write at count 3.
      add(1, 1, 0, 16'h0100, 16'd15, 1);
      add(1, 1, 0, 16'h0101, 16'd15, 2);
      add(1, 1, 0, 16'h0102, 16'd15, 3);
      add(1, 1, 1, 16'h0103, 16'h0100, 3);
      add(1, 0, 1, '0, 16'h0101, 2);
      add(1, 0, 1, '0, 16'h0102, 1);
      add(1, 0, 1, '0, 16'h0103, 0);
      // While empty, read ignored and write accepted (no fall-through).
      add(1, 1, 1, 16'h0055, 16'h0103, 1);
      add(1, 0, 1, '0, 16'h0055, 0);
      // Five words, mid-operation reset, then fresh write/read.
      for (int i = 0; i < 5; i++) add(1, 1, 0, DW'(16'h0200 + i), 16'h0055, i + 1);
      add(0, 0, 0, '0, '0, 0);
      add(1, 1, 0, 16'h1234, '0, 1);
      add(1, 0, 1, '0, 16'h1234, 0);
      add(1, 0, 1, '0, 16'h1234, 0);

      foreach (tbl[i]) begin
         cyc(tbl[i].r, tbl[i].we, tbl[i].re, tbl[i].wd);
`ifndef SYNC_FIFO_OUT_REG_EN
         chk($sformatf("tbl%0d_rd_data", i), rd_data, tbl[i].e_rd);
`endif
         chk($sformatf("tbl%0d_full", i),         full,         DW'(tbl[i].e_full));
         chk($sformatf("tbl%0d_almost_full", i),  almost_full,  DW'(tbl[i].e_af));
         chk($sformatf("tbl%0d_empty", i),        empty,        DW'(tbl[i].e_empty));
         chk($sformatf("tbl%0d_almost_empty", i), almost_empty, DW'(tbl[i].e_ae));
      end

      // Full with simultaneous read: read accepted, write blocked.
      for (int i = 0; i < 16; i++) cyc(1, 1, 0, DW'(16'h0300 + i));
      chk("seq_full_set", full, 16'd1);
      cyc(1, 1, 1, 16'h03FF);
      chk("seq_full_cleared", full, 16'd0);
      chk("seq_full_af_kept", almost_full, 16'd1);
      for (int i = 1; i < 16; i++) cyc(1, 0, 1, '0);
      chk("seq_blocked_empty", empty, 16'd1);
      cyc(1, 0, 0, '0);
`ifndef SYNC_FIFO_OUT_REG_EN
      chk("seq_blocked_last", rd_data, 16'h030F);
`endif

      // Randomized traffic with phases biased toward filling, draining, or mixed.
      for (int i = 0; i < 3000; i++) begin
         int  ph;
         int  wp;
         int  rp;
         bit  r;
         ph = (i / 250) % 3;
         wp = (ph == 0) ? 80 : (ph == 1) ? 30 : 50;
         rp = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
         r  = ($urandom_range(0, 299) != 0);
         cyc(r, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
